// File: rtl/top_k_pkg.sv
// Shared types and constants for the top-K sorter controller.
//   state_e     : controller FSM states
//   CHAIN_W     : chain word width for the default data width (MSB = clear flag)
//   CLEAR_TOKEN : chain word that resets every cell it passes through
//   idx_w()     : index/counter width for a K-entry structure
package top_k_pkg;

    localparam int unsigned DEF_INTEGER_SIZE = 32;
    localparam int unsigned DEF_K            = 8;
    localparam int unsigned DEF_CNT_W        = 32;

    localparam int unsigned CHAIN_W = DEF_INTEGER_SIZE + 1;
    localparam logic [CHAIN_W-1:0] CLEAR_TOKEN = {1'b1, {DEF_INTEGER_SIZE{1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        OUTPUT
    } state_e;

    // Width able to index 0..n-1, never below one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/top_k_if.sv
// AXI-Stream style handshake bundle.
//   master : drives TDATA/TUSER/TVALID/TLAST, samples TREADY
//   slave  : samples TDATA/TVALID/TLAST, drives TREADY (no TUSER on input side)
interface top_k_if
    import top_k_pkg::*;
#(
    parameter int unsigned W = DEF_INTEGER_SIZE
);
    logic [W-1:0] TDATA;
    logic         TUSER;
    logic         TVALID;
    logic         TLAST;
    logic         TREADY;

    modport master (output TDATA, output TUSER, output TVALID, output TLAST, input TREADY);
    modport slave  (input TDATA, input TVALID, input TLAST, output TREADY);
endinterface

// File: rtl/top_k_result_ser.sv
// Snapshot of the K cell registers and their serialisation onto AXI-Stream.
//   clk, rst_n : clock, synchronous active-low reset
//   snap_en    : capture res_data/res_valid and start emitting slot 0
//   res_data   : cell i value at [i*INTEGER_SIZE +: INTEGER_SIZE]
//   res_valid  : cell i holds a value
//   m_axis     : result stream (TUSER = slot valid, TLAST on slot K-1)
//   done_c     : handshake of slot K-1 this cycle
module top_k_result_ser
    import top_k_pkg::*;
#(
    parameter int unsigned INTEGER_SIZE = DEF_INTEGER_SIZE,
    parameter int unsigned K            = DEF_K
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      snap_en,
    input  logic [K*INTEGER_SIZE-1:0] res_data,
    input  logic [K-1:0]              res_valid,
    top_k_if.master                   m_axis,
    output logic                      done_c
);

    localparam int unsigned IDX_W = idx_w(K);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(K - 1);

    logic [K-1:0][INTEGER_SIZE-1:0] snap_data_q, snap_data_d;
    logic [K-1:0]                   snap_valid_q, snap_valid_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic                           active_q, active_d;
    logic                           hs_c;
    logic                           last_c;

    // State registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            snap_data_q  <= '0;
            snap_valid_q <= '0;
            idx_q        <= '0;
            active_q     <= 1'b0;
        end else begin
            snap_data_q  <= snap_data_d;
            snap_valid_q <= snap_valid_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
        end
    end

    // Capture and index advance; index only moves on a handshake
    always_comb begin
        snap_data_d  = snap_data_q;
        snap_valid_d = snap_valid_q;
        idx_d        = idx_q;
        active_d     = active_q;
        hs_c         = active_q & m_axis.TREADY;
        last_c       = (idx_q == IDX_LAST);

        if (snap_en) begin
            snap_data_d  = res_data;
            snap_valid_d = res_valid;
            idx_d        = '0;
            active_d     = 1'b1;
        end else if (hs_c) begin
            if (last_c) begin
                idx_d    = '0;
                active_d = 1'b0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Stream outputs, all derived from registers; invalid slots read as zero
    always_comb begin
        m_axis.TVALID = active_q;
        m_axis.TUSER  = active_q & snap_valid_q[idx_q];
        m_axis.TDATA  = m_axis.TUSER ? snap_data_q[idx_q] : '0;
        m_axis.TLAST  = active_q & last_c;
        done_c        = hs_c & last_c;
    end

endmodule

// File: rtl/top_k_ctrl.sv
// Sequencer for a chain of K top_k_unit insertion cells.
//   clk, rst_n    : clock, synchronous active-low reset
//   s_axis        : batch input (TLAST closes a batch)
//   chain_*       : word stream into cell 0; chain_advance drives every cell's tx ready
//   res_data/valid: register contents of all K cells
//   m_axis        : K result slots, largest first
//   busy          : controller not idle
//   batch_len     : element count of the last completed batch (saturating)
module top_k_ctrl
    import top_k_pkg::*;
#(
    parameter int unsigned INTEGER_SIZE = DEF_INTEGER_SIZE,
    parameter int unsigned K            = DEF_K,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    top_k_if.slave                    s_axis,
    output logic [INTEGER_SIZE:0]     chain_TDATA,
    output logic                      chain_TVALID,
    output logic                      chain_TLAST,
    output logic                      chain_advance,
    input  logic [K*INTEGER_SIZE-1:0] res_data,
    input  logic [K-1:0]              res_valid,
    top_k_if.master                   m_axis,
    output logic                      busy,
    output logic [CNT_W-1:0]          batch_len
);

    localparam int unsigned CW    = INTEGER_SIZE + 1;
    localparam int unsigned DRN_W = idx_w(K);
    localparam logic [CW-1:0]    CLEAR_WORD = {1'b1, {INTEGER_SIZE{1'b0}}};
    localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(K - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic [CNT_W-1:0]   batch_len_q, batch_len_d;
    logic [DRN_W-1:0]   drain_q, drain_d;
    logic               snap_c;
    logic               done_c;

    // State registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            batch_len_q <= '0;
            drain_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            batch_len_q <= batch_len_d;
            drain_q     <= drain_d;
        end
    end

    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign busy      = (state_q != IDLE);
    assign batch_len = batch_len_q;

    // Next state and chain/input control
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        batch_len_d    = batch_len_q;
        drain_d        = drain_q;
        snap_c         = 1'b0;
        s_axis.TREADY  = 1'b0;
        chain_TDATA    = '0;
        chain_TVALID   = 1'b0;
        chain_TLAST    = 1'b0;
        chain_advance  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (s_axis.TVALID) state_d = CLEAR;
            end
            CLEAR: begin
                chain_TDATA   = CLEAR_WORD;
                chain_TVALID  = 1'b1;
                chain_TLAST   = 1'b1;
                chain_advance = 1'b1;
                cnt_d         = '0;
                drain_d       = '0;
                state_d       = STREAM;
            end
            STREAM: begin
                // Chain never stalls: an idle input simply becomes a bubble
                chain_advance = 1'b1;
                s_axis.TREADY = 1'b1;
                chain_TDATA   = {1'b0, s_axis.TDATA};
                chain_TVALID  = s_axis.TVALID;
                chain_TLAST   = s_axis.TLAST;
                if (s_axis.TVALID) begin
                    cnt_d = cnt_inc;
                    if (s_axis.TLAST) begin
                        batch_len_d = cnt_inc;
                        state_d     = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // K-1 edges for the last element to reach the tail, plus one margin
                chain_advance = 1'b1;
                if (drain_q == DRAIN_LAST) begin
                    snap_c  = 1'b1;
                    state_d = OUTPUT;
                end else begin
                    drain_d = drain_q + DRN_W'(1);
                end
            end
            OUTPUT: begin
                if (done_c) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    top_k_result_ser #(
        .INTEGER_SIZE (INTEGER_SIZE),
        .K            (K)
    ) u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .snap_en   (snap_c),
        .res_data  (res_data),
        .res_valid (res_valid),
        .m_axis    (m_axis),
        .done_c    (done_c)
    );

endmodule

// File: tb/tb_top_k_ctrl.sv
// Bench for top_k_ctrl with K=4 and a behavioural chain of insertion cells.
module tb_top_k_ctrl;
    import top_k_pkg::*;

    localparam int unsigned W     = 32;
    localparam int unsigned K     = 4;
    localparam int unsigned CNT_W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    top_k_if #(.W(W)) s_if ();
    top_k_if #(.W(W)) m_if ();

    logic [W:0]       chain_TDATA;
    logic             chain_TVALID;
    logic             chain_TLAST;
    logic             chain_advance;
    logic             busy;
    logic [CNT_W-1:0] batch_len;

    logic [K-1:0][W-1:0] cell_val = '0;
    logic [K-1:0]        cell_ok  = '0;
    logic [K-1:0][W:0]   tx_d     = '0;
    logic [K-1:0]        tx_v     = '0;

    int n_cmp = 0;
    int n_err = 0;
    logic [W:0] chain_log [$];

    top_k_ctrl #(
        .INTEGER_SIZE (W),
        .K            (K),
        .CNT_W        (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis        (s_if),
        .chain_TDATA   (chain_TDATA),
        .chain_TVALID  (chain_TVALID),
        .chain_TLAST   (chain_TLAST),
        .chain_advance (chain_advance),
        .res_data      (cell_val),
        .res_valid     (cell_ok),
        .m_axis        (m_if),
        .busy          (busy),
        .batch_len     (batch_len)
    );

    // Insertion cell chain: keep the larger value, forward the other one (ties forward)
    always @(posedge clk) begin
        logic [W:0] rd;
        logic       rv;
        if (chain_advance) begin
            for (int i = 0; i < K; i++) begin
                if (i == 0) begin
                    rd = chain_TDATA;
                    rv = chain_TVALID;
                end else begin
                    rd = tx_d[i-1];
                    rv = tx_v[i-1];
                end
                if (!rv) begin
                    tx_v[i] <= 1'b0;
                end else if (rd[W]) begin
                    cell_val[i] <= '0;
                    cell_ok[i]  <= 1'b0;
                    tx_d[i]     <= rd;
                    tx_v[i]     <= 1'b1;
                end else if (rd[W-1:0] > cell_val[i]) begin
                    cell_val[i] <= rd[W-1:0];
                    cell_ok[i]  <= 1'b1;
                    tx_d[i]     <= {1'b0, cell_val[i]};
                    tx_v[i]     <= cell_ok[i];
                end else begin
                    tx_d[i] <= rd;
                    tx_v[i] <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chain_TVALID && chain_advance) chain_log.push_back(chain_TDATA);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_batch(input int unsigned vals [$], input bit gaps);
        for (int i = 0; i < vals.size(); i++) begin
            bit hs;
            int guard;
            s_if.TDATA  = vals[i];
            s_if.TLAST  = (i == vals.size() - 1);
            s_if.TVALID = 1'b1;
            hs    = 1'b0;
            guard = 0;
            while (!hs && guard < 50) begin
                @(negedge clk);
                hs = s_if.TVALID && s_if.TREADY;
                @(posedge clk);
                #1;
                guard++;
            end
            s_if.TVALID = 1'b0;
            s_if.TLAST  = 1'b0;
            if (!hs) begin
                check_eq("s_accept_timeout", 64'(guard), 64'(0));
                return;
            end
            if (gaps && i < vals.size() - 1) repeat (2) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic collect(input int unsigned exp_d [$], input logic [K-1:0] exp_u,
                           input bit toggle, input int unsigned exp_len);
        int n;
        int cyc;
        int first;
        bit s_rdy_seen;
        n          = 0;
        cyc        = 0;
        first      = -1;
        s_rdy_seen = 1'b0;
        m_if.TREADY = 1'b1;
        while (n < K && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (m_if.TVALID && first < 0) first = cyc;
            if (m_if.TVALID && s_if.TREADY) s_rdy_seen = 1'b1;
            if (m_if.TVALID) begin
                if (m_if.TREADY) begin
                    check_eq($sformatf("data%0d", n), 64'(m_if.TDATA), 64'(exp_d[n]));
                    check_eq($sformatf("user%0d", n), 64'(m_if.TUSER), 64'(exp_u[n]));
                    check_eq($sformatf("last%0d", n), 64'(m_if.TLAST), 64'(n == K - 1));
                    n++;
                end else begin
                    check_eq($sformatf("stall_data%0d", n), 64'(m_if.TDATA), 64'(exp_d[n]));
                end
            end
            @(posedge clk);
            #1;
            if (toggle) m_if.TREADY = ~m_if.TREADY;
        end
        m_if.TREADY = 1'b1;
        check_eq("slot_count", 64'(n), 64'(K));
        check_eq("latency", 64'(first), 64'(K + 1));
        check_eq("s_ready_in_output", 64'(s_rdy_seen), 64'(0));
        @(negedge clk);
        check_eq("busy_after", 64'(busy), 64'(0));
        check_eq("m_valid_after", 64'(m_if.TVALID), 64'(0));
        check_eq("batch_len", 64'(batch_len), 64'(exp_len));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int unsigned b [$];
        s_if.TDATA  = '0;
        s_if.TVALID = 1'b0;
        s_if.TLAST  = 1'b0;
        s_if.TUSER  = 1'b0;
        m_if.TREADY = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_batch_len", 64'(batch_len), 64'(0));
        check_eq("rst_m_valid", 64'(m_if.TVALID), 64'(0));
        check_eq("rst_s_ready", 64'(s_if.TREADY), 64'(0));
        check_eq("rst_advance", 64'(chain_advance), 64'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic batch, clear token precedes first element
        chain_log.delete();
        b = {5, 3, 9, 1};
        send_batch(b, 1'b0);
        check_eq("chain_clear", 64'(chain_log[0]), 64'h1_0000_0000);
        check_eq("chain_first", 64'(chain_log[1]), 64'h0_0000_0005);
        check_eq("chain_words", 64'(chain_log.size()), 64'(5));
        collect('{9, 5, 3, 1}, 4'b1111, 1'b0, 4);

        // Short batch leaves trailing slots invalid
        b = {7, 2};
        send_batch(b, 1'b0);
        collect('{7, 2, 0, 0}, 4'b0011, 1'b0, 2);

        // Long batch with duplicates
        chain_log.delete();
        b = {4, 8, 4, 1, 8, 6, 2, 9, 3, 4};
        send_batch(b, 1'b0);
        check_eq("chain_words_long", 64'(chain_log.size()), 64'(11));
        collect('{9, 8, 8, 6}, 4'b1111, 1'b0, 10);

        // Downstream backpressure
        b = {5, 3, 9, 1};
        send_batch(b, 1'b0);
        collect('{9, 5, 3, 1}, 4'b1111, 1'b1, 4);

        // Input bubbles
        chain_log.delete();
        send_batch(b, 1'b1);
        check_eq("chain_words_gaps", 64'(chain_log.size()), 64'(5));
        collect('{9, 5, 3, 1}, 4'b1111, 1'b0, 4);

        // Reset mid-stream, then a clean batch
        s_if.TDATA  = 11;
        s_if.TLAST  = 1'b0;
        s_if.TVALID = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check_eq("mid_busy", 64'(busy), 64'(1));
        s_if.TVALID = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mrst_busy", 64'(busy), 64'(0));
        check_eq("mrst_advance", 64'(chain_advance), 64'(0));
        check_eq("mrst_chain_valid", 64'(chain_TVALID), 64'(0));
        check_eq("mrst_m_valid", 64'(m_if.TVALID), 64'(0));
        check_eq("mrst_batch_len", 64'(batch_len), 64'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        b = {2, 6};
        send_batch(b, 1'b0);
        collect('{6, 2, 0, 0}, 4'b0011, 1'b0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/top_k_ctrl.md
Name: top_k_ctrl

Overview:
- Sequencer for a chain of K top_k_unit insertion cells.
- Accepts batches of unsigned integers on an AXI-Stream slave. Before each batch it injects a clear token into the chain, then streams the batch in and waits for the chain to settle.
- Serialises the K cell registers (largest first) onto an AXI-Stream master.
- Sits between the network RX stream and the sorter chain; its result stream feeds TX.

Parameters:
- INTEGER_SIZE, 32, data width; chain words are INTEGER_SIZE+1 wide, MSB = clear flag.
- K, 8, number of cells in the chain (>=2).
- CNT_W, 32, width of the per-batch element counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- s_axis_TDATA  in  INTEGER_SIZE  batch element
- s_axis_TVALID  in  1  element valid
- s_axis_TLAST  in  1  last element of batch
- s_axis_TREADY  out  1  controller accepts element
- chain_TDATA  out  INTEGER_SIZE+1  to cell 0 rx data
- chain_TVALID  out  1  to cell 0 rx valid
- chain_TLAST  out  1  to cell 0 rx last
- chain_advance  out  1  wired to every cell's tx_data_TREADY
- res_data  in  K*INTEGER_SIZE  cell i register_TDATA at bits [i*INTEGER_SIZE +: INTEGER_SIZE]
- res_valid  in  K  cell i register_TVALID
- m_axis_TDATA  out  INTEGER_SIZE  result word
- m_axis_TUSER  out  1  result slot valid; 0 = batch shorter than K or value 0
- m_axis_TVALID  out  1  result valid
- m_axis_TLAST  out  1  asserted on slot K-1
- m_axis_TREADY  in  1  downstream ready
- busy  out  1  high in every state except IDLE
- batch_len  out  CNT_W  elements in the last completed batch; saturates at all-ones

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE; all outputs 0; chain_advance=0; batch_len=0.
  - Reset mid-operation aborts the batch with no partial output.
  - Cells have no reset, so correctness relies on the clear issued before every batch.
- FSM states IDLE, CLEAR, STREAM, DRAIN, OUTPUT:
  - IDLE: s_axis_TREADY=0. Go to CLEAR when s_axis_TVALID=1.
  - CLEAR: exactly 1 cycle.
    - chain_TDATA={1'b1, 0}, chain_TVALID=1, chain_TLAST=1, chain_advance=1.
    - Element counter cleared. Go to STREAM.
  - STREAM:
    - chain_advance=1, s_axis_TREADY=1.
    - Combinational pass-through: chain_TDATA={1'b0, s_axis_TDATA}, chain_TVALID=s_axis_TVALID, chain_TLAST=s_axis_TLAST.
    - s_axis_TVALID=0 produces a bubble; the chain is never stalled, since stalling drops in-flight data.
    - Counter increments per accepted element, saturating.
    - On accepted TLAST: latch batch_len and go to DRAIN.
  - DRAIN:
    - chain_advance=1, chain_TVALID=0, s_axis_TREADY=0.
    - Lasts exactly K cycles; the last element reaches cell K-1 K-1 edges after acceptance, plus 1 margin.
    - On exit, snapshot res_data/res_valid into an internal buffer. Go to OUTPUT.
  - OUTPUT:
    - chain_advance=0. Emit slots 0..K-1 from the snapshot: TDATA = value (0 if slot invalid), TUSER = slot valid.
    - Standard AXIS: TVALID held and data stable until TREADY; index advances only on handshake; TLAST on index K-1.
    - After the K-1 handshake go to IDLE. New input is accepted no earlier than the cycle after.
- Ordering: cell 0 holds the maximum, so slots come out in descending order.
  - Ties forward to the next cell, so duplicates occupy successive slots.
  - Value 0 never beats a cleared cell; it yields TUSER=0.
- Batches longer than K: surplus smallest values exit the chain tail; the controller ignores them.
- s_axis_TLAST on the first element gives a 1-element batch; valid.
- Batch latency: acceptance of TLAST to first m_axis_TVALID = K+1 cycles.

Decomposition:
- Package top_k_pkg:
  - state enum (IDLE, CLEAR, STREAM, DRAIN, OUTPUT)
  - localparam CHAIN_W=INTEGER_SIZE+1
  - CLEAR_TOKEN constant
  - clog2-based index/drain counter widths
- One sub-module: top_k_result_ser. Holds snapshot registers plus the AXIS serialiser with the index counter, TLAST and TUSER generation.

Test Plan (bench instantiates top_k_ctrl driving K=4 top_k_unit cells):
- Reset, batch {5,3,9,1} TLAST on 1 -> chain sees 0x1_00000000 one cycle before 5. Output 9,5,3,1, TUSER=1111, TLAST on 4th. batch_len=4.
- Batch {7,2} -> output 7,2,0,0; TUSER 1,1,0,0.
- Batch of 10: {4,8,4,1,8,6,2,9,3,4} -> output 9,8,8,6, all TUSER=1. batch_len=10.
- m_axis_TREADY toggling 1/0 each cycle on batch {5,3,9,1} -> same 4 words, no drops or duplicates. s_axis_TREADY=0 until the final handshake, then IDLE.
- Input gaps (TVALID 1,0,0,1,...) on batch {5,3,9,1} -> identical result to scenario 1.
- rst_n low for 1 cycle mid-STREAM -> all outputs 0 next cycle. Following batch {2,6} yields 6,2,0,0, not polluted by pre-reset data.
